// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit-path arbiter: FSM encoding,
// byte width and slice helpers.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

  function automatic int slice_off(input int idx, input int width);
    return idx * BYTE_W * width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [idx_width(NUM_REQ)-1:0]   rr_ptr,
  output logic                            valid,
  output logic [idx_width(NUM_REQ)-1:0]   index,
  output logic [NUM_REQ-1:0]              onehot
);

  localparam int IDX_W = idx_width(NUM_REQ);

  always_comb begin
    int cand;
    cand   = 0;
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    // Walk from the far end backwards so the candidate closest to rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
    if (valid) onehot = NUM_REQ'(1) << index;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART transmit path: latches the winner's frame,
// strobes transmit once, follows the busy flag and returns done or err.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 5,
  parameter int START_TIMEOUT = 255
) (
  input  logic                            masterClock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [BYTE_W*NUM_REQ-1:0]       reqStatus,
  input  logic [BYTE_W*WIDTH*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              err,
  output logic [BYTE_W-1:0]               status,
  output logic [BYTE_W*WIDTH-1:0]         outputData,
  output logic                            transmit,
  input  logic                            transmitting,
  output logic [1:0]                      dbg_state
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int DATA_W = BYTE_W * WIDTH;
  localparam int CNT_W  = idx_width(START_TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [BYTE_W-1:0]   status_q, status_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                transmit_q, transmit_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    next_ptr;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx),
    .onehot (pick_onehot)
  );

  assign next_ptr = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = '0;
    status_d   = status_q;
    data_d     = data_q;
    transmit_d = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A busy UART here may be finishing a frame started before reset.
        if (pick_valid && !transmitting) begin
          grant_d  = pick_onehot;
          winner_d = pick_idx;
          status_d = reqStatus[int'(pick_idx)*BYTE_W +: BYTE_W];
          data_d   = reqData[slice_off(int'(pick_idx), WIDTH) +: DATA_W];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        transmit_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (transmitting) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
          err_d    = grant_q;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!transmitting) begin
          done_d   = grant_q;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      status_q   <= '0;
      data_q     <= '0;
      transmit_q <= 1'b0;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      status_q   <= status_d;
      data_q     <= data_d;
      transmit_q <= transmit_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign err        = err_q;
  assign status     = status_q;
  assign outputData = data_q;
  assign transmit   = transmit_q;
  assign dbg_state  = state_q;

endmodule
